weights_loader: RTL

WEIGHTS_LOADER -- requirements
Module: weights_loader

---
 rtl/weights_loader_pkg.sv | 6 +
 rtl/weights_ram.sv | 21 ++
 rtl/weights_loader.sv | 67 ++++++
 3 files changed

// File: rtl/weights_loader_pkg.sv
// weights_loader_pkg: shared state encoding and memory geometry for the weights loader
package weights_loader_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;
  localparam int WEIGHT_DEPTH = 256;
  localparam int WEIGHT_AW = 8;
endpackage

// File: rtl/weights_ram.sv
// weights_ram: simple dual-port weight store with registered, read-first output
module weights_ram
  import weights_loader_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [WEIGHT_AW-1:0] wa,
  input  logic [N-1:0]         wd,
  input  logic [WEIGHT_AW-1:0] ra,
  output logic [N-1:0]         rd
);
  logic [N-1:0] mem [WEIGHT_DEPTH];
  // storage has no reset so it maps onto block RAM; only the output register clears
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  always_ff @(posedge clk)
    rd <= !rst_n ? '0 : mem[ra];
endmodule

// File: rtl/weights_loader.sv
// weights_loader: streams a block of signed weight words into RAM and tracks a running XOR checksum
module weights_loader
  import weights_loader_pkg::*;
#(
  parameter int N = 8,
  parameter int Q = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [7:0]   load_len,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  input  logic [7:0]   rd_addr,
  output logic [N-1:0] rd_data,
  output logic         loaded,
  output logic         done,
  output logic [N-1:0] checksum
);
  if (Q >= N) begin : g_bad_q
    $error("Q must be smaller than N");
  end
  state_t state, state_nx;
  logic [WEIGHT_AW-1:0] wr_ptr, len;
  logic go, xfer, last;
  assign in_ready = state == LOAD;
  assign go = start && state != LOAD;
  assign xfer = in_valid && in_ready;
  assign last = wr_ptr == len;
  always_comb begin
    state_nx = go ? LOAD : (xfer && last) ? READY : state;
  end
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_nx;
  // pointer saturates at len so a 256-word load never wraps back to 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      len <= '0;
      checksum <= '0;
      loaded <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= xfer && last;
      if (go) begin
        len <= load_len;
        wr_ptr <= '0;
        checksum <= '0;
        loaded <= 1'b0;
      end else if (xfer) begin
        checksum <= checksum ^ in_data;
        if (!last) wr_ptr <= wr_ptr + 1'b1;
        if (last) loaded <= 1'b1;
      end
    end
  end
  weights_ram #(.N(N)) u_ram (
    .clk(clk),
    .rst_n(rst_n),
    .we(xfer),
    .wa(wr_ptr),
    .wd(in_data),
    .ra(rd_addr),
    .rd(rd_data)
  );
endmodule
